// File: rtl/cpu_pkg.sv
// Shared defaults and constants for the CPU register-file slice.
package cpu_pkg;

  localparam int unsigned DEFAULT_DATA_W = 32;
  localparam int unsigned DEFAULT_ADDR_W = 5;
  localparam int unsigned REG_COUNT      = 2 ** DEFAULT_ADDR_W;
  localparam int unsigned ZERO_REG       = 0;

endpackage

// File: rtl/cpu_scoreboard.sv
// Load scoreboard: one busy bit per register, plus hazard flags for two read ports.
module cpu_scoreboard
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W = DEFAULT_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              set_en,
  input  logic [ADDR_W-1:0] set_addr,
  input  logic              clr_en,
  input  logic [ADDR_W-1:0] clr_addr,
  input  logic [ADDR_W-1:0] qa,
  input  logic [ADDR_W-1:0] qb,
  output logic              haz_a,
  output logic              haz_b
);

  localparam int unsigned NRegs = 2 ** ADDR_W;

  logic [NRegs-1:0] busy_q, busy_d;

  // Set is applied after clear so a newly issued load supersedes a completing one.
  always_comb begin
    busy_d = busy_q;
    if (clr_en) begin
      busy_d[clr_addr] = 1'b0;
    end
    if (set_en && (set_addr != ADDR_W'(ZERO_REG))) begin
      busy_d[set_addr] = 1'b1;
    end
    busy_d[ZERO_REG] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  // A load completing this cycle resolves the hazard immediately.
  assign haz_a = busy_q[qa] && !(clr_en && (clr_addr == qa));
  assign haz_b = busy_q[qb] && !(clr_en && (clr_addr == qb));

endmodule

// File: rtl/cpu_regfile_read.sv
// Register file with writeback bypass, load scoreboard stall and registered operand outputs.
module cpu_regfile_read
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W = DEFAULT_DATA_W,
  parameter int unsigned ADDR_W = DEFAULT_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              wb_load,
  input  logic              iss_load,
  input  logic [ADDR_W-1:0] iss_rd,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_ra,
  input  logic [ADDR_W-1:0] req_rb,
  output logic              req_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b
);

  localparam int unsigned NRegs = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [NRegs];
  logic              haz_a, haz_b;
  logic              accept;
  logic [DATA_W-1:0] rd_a, rd_b;

  cpu_scoreboard #(
    .ADDR_W(ADDR_W)
  ) u_scoreboard (
    .clk     (clk),
    .rst     (rst),
    .set_en  (iss_load),
    .set_addr(iss_rd),
    .clr_en  (wb_en && wb_load),
    .clr_addr(wb_addr),
    .qa      (req_ra),
    .qb      (req_rb),
    .haz_a   (haz_a),
    .haz_b   (haz_b)
  );

  assign req_ready = !(haz_a || haz_b);
  assign accept    = req_valid && req_ready;

  // Same-cycle writeback is forwarded so the consumer never sees stale data.
  always_comb begin
    rd_a = regs_q[req_ra];
    rd_b = regs_q[req_rb];
    if (wb_en && (wb_addr == req_ra)) rd_a = wb_data;
    if (wb_en && (wb_addr == req_rb)) rd_b = wb_data;
    if (req_ra == ADDR_W'(ZERO_REG)) rd_a = '0;
    if (req_rb == ADDR_W'(ZERO_REG)) rd_b = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NRegs; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wb_en && (wb_addr != ADDR_W'(ZERO_REG))) begin
      regs_q[wb_addr] <= wb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_a     <= '0;
      out_b     <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_a     <= rd_a;
      out_b     <= rd_b;
    end else begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cpu_regfile_read.sv
// Bench for cpu_regfile_read: directed scenarios plus randomized traffic against an array model.
module tb_cpu_regfile_read;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          wb_en, wb_load, iss_load, req_valid;
  logic [AW-1:0] wb_addr, iss_rd, req_ra, req_rb;
  logic [DW-1:0] wb_data;
  logic          req_ready, out_valid;
  logic [DW-1:0] out_a, out_b;

  always #5 clk = ~clk;

  cpu_regfile_read #(
    .DATA_W(DW),
    .ADDR_W(AW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .wb_en    (wb_en),
    .wb_addr  (wb_addr),
    .wb_data  (wb_data),
    .wb_load  (wb_load),
    .iss_load (iss_load),
    .iss_rd   (iss_rd),
    .req_valid(req_valid),
    .req_ra   (req_ra),
    .req_rb   (req_rb),
    .req_ready(req_ready),
    .out_valid(out_valid),
    .out_a    (out_a),
    .out_b    (out_b)
  );

  int unsigned n_cmp  = 0;
  int unsigned n_fail = 0;

  // Reference model state
  logic [DW-1:0] m_reg [NR];
  bit            m_busy[NR];
  bit            m_ov;
  logic [DW-1:0] m_a, m_b;
  bit            m_hold;

  function automatic bit m_haz(input logic [AW-1:0] a);
    return m_busy[a] && !(wb_en && wb_load && wb_addr == a);
  endfunction

  function automatic bit m_ready();
    return !(m_haz(req_ra) || m_haz(req_rb));
  endfunction

  function automatic logic [DW-1:0] m_read(input logic [AW-1:0] a);
    if (a == 0) return '0;
    if (wb_en && wb_addr == a) return wb_data;
    return m_reg[a];
  endfunction

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_in(input bit r, input bit we, input int wa, input logic [DW-1:0] wd,
                        input bit wl, input bit il, input int ird,
                        input bit rv, input int ra, input int rb);
    rst = r; wb_en = we; wb_addr = AW'(wa); wb_data = wd; wb_load = wl;
    iss_load = il; iss_rd = AW'(ird); req_valid = rv; req_ra = AW'(ra); req_rb = AW'(rb);
  endtask

  // One clock: compare ready before the edge, advance model on the edge, compare outputs after.
  task automatic step(input bit chk_rdy);
    bit acc;
    #1;
    if (chk_rdy) check("req_ready", {31'b0, req_ready}, {31'b0, m_ready()});
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < NR; i++) begin
        m_reg[i] = '0;
        m_busy[i] = 1'b0;
      end
      m_ov = 1'b0; m_a = '0; m_b = '0; m_hold = 1'b0;
    end else begin
      acc = req_valid && m_ready();
      m_ov = acc;
      if (acc) begin
        m_a = m_read(req_ra);
        m_b = m_read(req_rb);
      end
      m_hold = req_valid && !acc;
      if (wb_en && wb_addr != 0) m_reg[wb_addr] = wb_data;
      if (wb_en && wb_load) m_busy[wb_addr] = 1'b0;
      if (iss_load && iss_rd != 0) m_busy[iss_rd] = 1'b1;
    end
    @(negedge clk);
    check("out_valid", {31'b0, out_valid}, {31'b0, m_ov});
    check("out_a", out_a, m_a);
    check("out_b", out_b, m_b);
  endtask

  initial begin
    for (int i = 0; i < NR; i++) begin
      m_reg[i] = '0;
      m_busy[i] = 1'b0;
    end
    m_ov = 0; m_a = '0; m_b = '0; m_hold = 0;

    // Reset (busy state unknown before the first edge, so skip the ready check)
    set_in(1, 0, 0, '0, 0, 0, 0, 0, 0, 0);
    step(0);
    step(1);

    // Read after reset
    set_in(0, 0, 0, '0, 0, 0, 0, 1, 3, 0);
    step(1);
    check("t1_valid", {31'b0, out_valid}, 32'd1);
    check("t1_a", out_a, 32'd0);
    check("t1_b", out_b, 32'd0);

    // Bypass, then a plain read of the written register
    set_in(0, 1, 5, 32'hDEADBEEF, 0, 0, 0, 1, 5, 0);
    step(1);
    check("t2_bypass", out_a, 32'hDEADBEEF);
    set_in(0, 0, 0, '0, 0, 0, 0, 1, 5, 0);
    step(1);
    check("t2_reread", out_a, 32'hDEADBEEF);

    // Load stall on r7 and release on load writeback
    set_in(0, 0, 0, '0, 0, 1, 7, 0, 0, 0);
    step(1);
    set_in(0, 0, 0, '0, 0, 0, 0, 1, 7, 0);
    for (int i = 0; i < 3; i++) begin
      #1 check("t3_stall_rdy", {31'b0, req_ready}, 32'd0);
      step(1);
      check("t3_stall_ov", {31'b0, out_valid}, 32'd0);
    end
    set_in(0, 1, 7, 32'h1234, 1, 0, 0, 1, 7, 0);
    #1 check("t3_release_rdy", {31'b0, req_ready}, 32'd1);
    step(1);
    check("t3_release_a", out_a, 32'h1234);

    // r0 write discarded; load to r0 does not stall
    set_in(0, 1, 0, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 0);
    step(1);
    set_in(0, 0, 0, '0, 0, 0, 0, 1, 0, 0);
    step(1);
    check("t4_r0", out_a, 32'd0);
    set_in(0, 0, 0, '0, 0, 1, 0, 1, 0, 0);
    step(1);
    set_in(0, 0, 0, '0, 0, 0, 0, 1, 0, 0);
    #1 check("t4_r0_rdy", {31'b0, req_ready}, 32'd1);
    step(1);

    // Set beats clear on the same register
    set_in(0, 1, 9, 32'h99, 1, 1, 9, 0, 0, 0);
    step(1);
    set_in(0, 0, 0, '0, 0, 0, 0, 1, 9, 0);
    #1 check("t5_stall_rdy", {31'b0, req_ready}, 32'd0);
    step(1);
    set_in(0, 1, 9, 32'h55, 1, 0, 0, 1, 9, 0);
    step(1);
    check("t5_release_a", out_a, 32'h55);

    // Reset while busy[4]=1 and out_valid=1
    set_in(0, 0, 0, '0, 0, 1, 4, 1, 3, 0);
    step(1);
    check("t6_pre_ov", {31'b0, out_valid}, 32'd1);
    set_in(1, 0, 0, '0, 0, 0, 0, 1, 4, 0);
    step(1);
    check("t6_rst_ov", {31'b0, out_valid}, 32'd0);
    set_in(0, 0, 0, '0, 0, 0, 0, 1, 4, 0);
    #1 check("t6_rdy", {31'b0, req_ready}, 32'd1);
    step(1);
    check("t6_ov", {31'b0, out_valid}, 32'd1);
    check("t6_a", out_a, 32'd0);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      logic [AW-1:0] ra, rb;
      bit rv;
      if (m_hold) begin
        rv = 1; ra = req_ra; rb = req_rb;
      end else begin
        rv = ($urandom % 4) != 0;
        ra = ($urandom % 4 == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
        rb = ($urandom % 4 == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
      end
      rst      = ($urandom % 300) == 0;
      wb_en    = ($urandom % 2) != 0;
      wb_load  = ($urandom % 2) != 0;
      wb_data  = $urandom;
      case ($urandom % 4)
        0: wb_addr = ra;
        1: wb_addr = rb;
        default: wb_addr = AW'($urandom_range(0, 7));
      endcase
      iss_load  = ($urandom % 5) == 0;
      iss_rd    = AW'($urandom_range(0, 7));
      req_valid = rv;
      req_ra    = ra;
      req_rb    = rb;
      step(1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
